// File: rtl/fp_mult_li_initiator_if.sv
// Ready-valid link between the multiplier initiator and any LI multiplier
// responder: operand channel (m_*) and result channel (s_*).
interface fp_mult_li_initiator_if;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] s_result;
  logic        s_exception;
  logic        s_overflow;
  logic        s_underflow;
  logic        s_valid;
  logic        s_ready;

  modport master (
    output m_a, m_b, m_valid, s_ready,
    input  m_ready, s_result, s_exception, s_overflow, s_underflow, s_valid
  );

  modport slave (
    input  m_a, m_b, m_valid, s_ready,
    output m_ready, s_result, s_exception, s_overflow, s_underflow, s_valid
  );
endinterface

// File: rtl/fp_mult_li_initiator.sv
// Initiator for the LI floating-point multiplier: streams buffered operand
// pairs to a responder under a credit limit and collects in-order results.
module fp_mult_li_initiator #(
  parameter int DEPTH           = 16,
  parameter int MAX_OUTSTANDING = 8,
  localparam int AW             = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  // host load / control
  input  logic                          ld_en,
  input  logic [AW-1:0]                 ld_addr,
  input  logic [31:0]                   ld_a,
  input  logic [31:0]                   ld_b,
  input  logic                          start,
  input  logic [AW:0]                   num_ops,
  input  logic                          sink_stall,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    exc_count,
  // responder link
  fp_mult_li_initiator_if.master        bus,
  // result readback
  input  logic [AW-1:0]                 rd_addr,
  output logic [31:0]                   rd_result,
  output logic [2:0]                    rd_flags
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int             IFW     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IFW-1:0] MAXO    = IFW'(MAX_OUTSTANDING);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  // operand and result storage; contents are don't-care after reset
  logic [31:0] op_a    [DEPTH];
  logic [31:0] op_b    [DEPTH];
  logic [31:0] res_mem [DEPTH];
  logic [2:0]  flg_mem [DEPTH];

  state_t         state;
  logic [AW:0]    n_ops, issue_idx, recv_idx;
  logic [IFW-1:0] in_flight;
  logic [7:0]     exc_q;
  logic           mv_q, busy_q, done_q;
  logic [31:0]    ma_q, mb_q;

  logic        active, s_rdy, rx, acc, slot_free, present, last_acc;
  logic [AW:0] recv_nxt, n_clamp;

  // handshake and credit decode
  always_comb begin
    active    = (state == RUN) || (state == DRAIN);
    s_rdy     = active && !sink_stall && (in_flight != '0);
    rx        = bus.s_valid && s_rdy;
    acc       = mv_q && bus.m_ready;
    slot_free = !mv_q || bus.m_ready;
    // credit is judged on the pre-update count, so a same-cycle result
    // does not free a slot until the next cycle
    present   = (state == RUN) && slot_free && (issue_idx != n_ops) &&
                (in_flight < MAXO);
    // the pair being accepted is the last one once issue_idx hit n_ops
    last_acc  = acc && (issue_idx == n_ops);
    recv_nxt  = recv_idx + {{AW{1'b0}}, rx};
    n_clamp   = (num_ops > DEPTH_C) ? DEPTH_C : num_ops;
  end

  // run sequencing, operand issue, credit and exception bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      n_ops     <= '0;
      issue_idx <= '0;
      recv_idx  <= '0;
      in_flight <= '0;
      exc_q     <= '0;
      mv_q      <= 1'b0;
      ma_q      <= '0;
      mb_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_ops     <= n_clamp;
            issue_idx <= '0;
            recv_idx  <= '0;
            in_flight <= '0;
            exc_q     <= '0;
            busy_q    <= 1'b1;
            if (n_clamp == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
            end
          end
        end

        RUN, DRAIN: begin
          // operand slot: load a fresh pair or retire the accepted one
          if (present) begin
            mv_q      <= 1'b1;
            ma_q      <= op_a[issue_idx[AW-1:0]];
            mb_q      <= op_b[issue_idx[AW-1:0]];
            issue_idx <= issue_idx + 1'b1;
          end else if (acc) begin
            mv_q      <= 1'b0;
          end

          case ({present, rx})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
          endcase

          if (rx) begin
            recv_idx <= recv_nxt;
            if (bus.s_exception && (exc_q != 8'hFF))
              exc_q <= exc_q + 8'd1;
          end

          // finish as soon as the last result lands so done follows it
          // by exactly one edge
          if (state == RUN) begin
            if (last_acc) begin
              if (recv_nxt == n_ops) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state  <= DRAIN;
              end
            end
          end else if (recv_nxt == n_ops) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // host operand writes (IDLE only) and result capture
  always_ff @(posedge clk) begin
    if ((state == IDLE) && ld_en) begin
      op_a[ld_addr] <= ld_a;
      op_b[ld_addr] <= ld_b;
    end
    if (rx) begin
      res_mem[recv_idx[AW-1:0]] <= bus.s_result;
      flg_mem[recv_idx[AW-1:0]] <= {bus.s_exception, bus.s_overflow,
                                    bus.s_underflow};
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign exc_count   = exc_q;
  assign bus.m_valid = mv_q;
  assign bus.m_a     = ma_q;
  assign bus.m_b     = mb_q;
  assign bus.s_ready = s_rdy;
  assign rd_result   = res_mem[rd_addr];
  assign rd_flags    = flg_mem[rd_addr];

endmodule

// File: tb/tb_fp_mult_li_initiator.sv
// Bench for fp_mult_li_initiator: behavioural responder with random latency
// and backpressure, reference model of expected products and flags.
module tb_fp_mult_li_initiator;
  localparam int DEPTH = 16;
  localparam int MAXO  = 2;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_a = '0, ld_b = '0;
  logic          start = 1'b0;
  logic [AW:0]   num_ops = '0;
  logic          sink_stall = 1'b0;
  logic          busy, done;
  logic [7:0]    exc_count;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_result;
  logic [2:0]    rd_flags;

  always #5 clk = ~clk;

  fp_mult_li_initiator_if bus ();

  fp_mult_li_initiator #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_a(ld_a), .ld_b(ld_b), .start(start), .num_ops(num_ops),
    .sink_stall(sink_stall), .busy(busy), .done(done),
    .exc_count(exc_count), .bus(bus), .rd_addr(rd_addr),
    .rd_result(rd_result), .rd_flags(rd_flags)
  );

  int errors = 0;
  int checks = 0;

  // reference single-precision multiply on normal operands, truncating;
  // returns {exception, overflow, underflow, result}
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin m = p[46:24]; e = e + 1; end
    else       m = p[45:23];
    if (e >= 255) return {3'b110, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b101, s, 31'h0};
    return {3'b000, s, e[7:0], m};
  endfunction

  // ---------------- behavioural responder ----------------
  typedef struct { logic [31:0] a; logic [31:0] b; int due; } pend_t;
  pend_t       pq[$];
  int          rcyc = 0;
  int          lat_max = 1;
  bit          mr_rnd = 1'b0;
  logic [34:0] rsp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pq.delete();
      bus.s_valid     <= 1'b0;
      bus.m_ready     <= 1'b0;
      bus.s_result    <= '0;
      bus.s_exception <= 1'b0;
      bus.s_overflow  <= 1'b0;
      bus.s_underflow <= 1'b0;
    end else begin
      rcyc <= rcyc + 1;
      if (bus.s_valid && bus.s_ready) void'(pq.pop_front());
      if (bus.m_valid && bus.m_ready)
        pq.push_back('{bus.m_a, bus.m_b, rcyc + int'($urandom_range(1, lat_max))});
      if (pq.size() != 0 && pq[0].due <= rcyc) begin
        rsp = fmul(pq[0].a, pq[0].b);
        bus.s_valid     <= 1'b1;
        bus.s_result    <= rsp[31:0];
        bus.s_exception <= rsp[34];
        bus.s_overflow  <= rsp[33];
        bus.s_underflow <= rsp[32];
      end else begin
        bus.s_valid <= 1'b0;
      end
      bus.m_ready <= mr_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- protocol monitor ----------------
  logic [63:0] acc_q[$];
  int          out_cnt = 0, max_infl = 0, stab_viol = 0, done_cnt = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [31:0] pa = '0, pb = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt <= 0;
      pv      <= 1'b0;
      pr      <= 1'b0;
    end else begin
      if (pv && !pr && (bus.m_valid !== 1'b1 || bus.m_a !== pa || bus.m_b !== pb))
        stab_viol <= stab_viol + 1;
      if (out_cnt + int'(bus.m_valid) > max_infl)
        max_infl <= out_cnt + int'(bus.m_valid);
      if (bus.m_valid && bus.m_ready) acc_q.push_back({bus.m_a, bus.m_b});
      out_cnt <= out_cnt + int'(bus.m_valid && bus.m_ready) - int'(bus.s_valid && bus.s_ready);
      if (done) done_cnt <= done_cnt + 1;
      pv <= bus.m_valid;
      pr <= bus.m_ready;
      pa <= bus.m_a;
      pb <= bus.m_b;
    end
  end

  // ---------------- reference operand image ----------------
  logic [31:0] mdl_a [DEPTH];
  logic [31:0] mdl_b [DEPTH];
  int          abase = 0, dbase = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
    ld_en = 1'b1; ld_addr = AW'(i); ld_a = a; ld_b = b;
    mdl_a[i] = a; mdl_b[i] = b;
    tick();
    ld_en = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(60, 200)), 23'($urandom)};
  endfunction

  task automatic load_random();
    for (int i = 0; i < DEPTH; i++) load(i, rnd_fp(), rnd_fp());
  endtask

  task automatic start_run(input int n);
    abase   = acc_q.size();
    dbase   = done_cnt;
    start   = 1'b1;
    num_ops = (AW+1)'(n);
    tick();
    start   = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input int n_exp);
    int w;
    int exc;
    logic [34:0] e;
    w = 0;
    while (done !== 1'b1 && w < 3000) begin tick(); w++; end
    chk("done_seen", done, 1);
    tick();
    chk("busy_low_after_done", busy, 0);
    chk("done_low_after_pulse", done, 0);
    chk("done_pulse_count", done_cnt - dbase, 1);
    chk("pairs_presented", acc_q.size() - abase, n_exp);
    exc = 0;
    for (int i = 0; i < n_exp; i++) begin
      if (abase + i < acc_q.size())
        chk($sformatf("pair_order[%0d]", i), acc_q[abase + i], {mdl_a[i], mdl_b[i]});
      e = fmul(mdl_a[i], mdl_b[i]);
      rd_addr = AW'(i);
      #1;
      chk($sformatf("result[%0d]", i), rd_result, e[31:0]);
      chk($sformatf("flags[%0d]", i), rd_flags, e[34:32]);
      if (e[34] && exc < 255) exc++;
    end
    chk("exc_count", exc_count, exc);
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_a", bus.m_a, 0);
    chk("rst_m_b", bus.m_b, 0);
    chk("rst_exc", exc_count, 0);
    reset_n = 1'b1;
    tick();

    // basic products
    load(0, 32'h3F800000, 32'h40000000);
    load(1, 32'h40400000, 32'h40400000);
    start_run(2);
    finish_run(2);
    rd_addr = 0; #1;
    chk("basic_1x2", rd_result, 32'h40000000);
    rd_addr = 1; #1;
    chk("basic_3x3", rd_result, 32'h41100000);
    chk("basic_flags", rd_flags, 3'b000);

    // overflow
    load(0, 32'h7F000000, 32'h7F000000);
    start_run(1);
    finish_run(1);
    rd_addr = 0; #1;
    chk("ovf_bit", rd_flags[1], 1);
    chk("ovf_exc_count", exc_count, 1);

    // zero-length run
    start_run(0);
    chk("zero_done_next", done, 1);
    chk("zero_no_valid", bus.m_valid, 0);
    finish_run(0);

    // credit limit under result stall, plus ignored start/ld_en mid-run
    load_random();
    sink_stall = 1'b1;
    start_run(DEPTH);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin
        ld_en = 1'b1; ld_addr = AW'(5); ld_a = 32'hDEADBEEF; ld_b = 32'h12345678;
        start = 1'b1; num_ops = 1;
      end
      tick();
      ld_en = 1'b0; start = 1'b0;
    end
    chk("credit_presented", acc_q.size() - abase, MAXO);
    chk("credit_no_valid", bus.m_valid, 0);
    chk("credit_s_ready_low", bus.s_ready, 0);
    sink_stall = 1'b0;
    finish_run(DEPTH);
    chk("credit_max_inflight", max_infl > MAXO, 0);

    // oversize num_ops clamps, random backpressure and latency
    mr_rnd = 1'b1; lat_max = 5;
    start_run(20);
    finish_run(DEPTH);

    load_random();
    start_run(DEPTH);
    finish_run(DEPTH);
    chk("operand_stability", stab_viol, 0);

    // reset during DRAIN
    mr_rnd = 1'b0; lat_max = 1;
    sink_stall = 1'b1;
    start_run(2);
    repeat (10) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_s_ready", bus.s_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_m_a", bus.m_a, 0);
    chk("mid_rst_exc", exc_count, 0);
    tick();
    reset_n = 1'b1;
    sink_stall = 1'b0;
    tick();
    load_random();
    start_run(5);
    finish_run(5);
    chk("final_max_inflight", max_infl > MAXO, 0);
    chk("final_stability", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
